// File: rtl/hash_target_cmp.sv
// Hash-versus-target comparator: loads a target, then compares streamed hash words MSW first.
// Optional HASH_CMP_CAPTURE_EN assembles each completed hash into hash_out.
module hash_target_cmp #(
   parameter int HASH_W = 256,
   parameter int WORD_W = 64,
   parameter int TGT_W  = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [TGT_W-1:0]  tgt_data,
   input  logic              tgt_valid,
   input  logic [WORD_W-1:0] hash_data,
   input  logic              hash_valid,
   output logic              hash_ready,
   output logic              hit_valid,
   output logic              hit,
   output logic              nonce_pop,
   output logic [HASH_W-1:0] hash_out,
   output logic [CNT_W-1:0]  hashes_done,
   output logic [CNT_W-1:0]  hits_found,
   output logic              running
);

   localparam int NW        = HASH_W / WORD_W;
   localparam int TGT_BEATS = HASH_W / TGT_W;
   localparam int BW        = (NW > 1) ? $clog2(NW) : 1;
   localparam int TW        = (TGT_BEATS > 1) ? $clog2(TGT_BEATS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [HASH_W-1:0]   tgt_q, tgt_d;
   logic [TW-1:0]       tgt_cnt_q, tgt_cnt_d;
   logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
   logic                lt_q, lt_d, gt_q, gt_d;
   logic                hit_q, hit_d, hit_valid_q, hit_valid_d;
   logic [CNT_W-1:0]    hashes_done_q, hashes_done_d;
   logic [CNT_W-1:0]    hits_found_q, hits_found_d;

   logic [WORD_W-1:0]        slice;
   logic [HASH_W+TGT_W-1:0]  tgt_cat;
   logic                     beat_acc, last_beat;
   logic                     lt_prior, gt_prior, lt_cur, gt_cur;

`ifdef HASH_CMP_CAPTURE_EN
   logic [HASH_W-1:0]        asm_q, asm_d, hash_out_q, hash_out_d;
   logic [HASH_W+WORD_W-1:0] hash_cat;
`endif

   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      tgt_cnt_d     = tgt_cnt_q;
      beat_cnt_d    = beat_cnt_q;
      lt_d          = lt_q;
      gt_d          = gt_q;
      hit_d         = hit_q;
      hit_valid_d   = 1'b0;
      hashes_done_d = hashes_done_q;
      hits_found_d  = hits_found_q;
`ifdef HASH_CMP_CAPTURE_EN
      asm_d         = asm_q;
      hash_out_d    = hash_out_q;
      hash_cat      = {asm_q, hash_data};
`endif

      slice = '0;
      for (int unsigned i = 0; i < NW; i++) begin
         if (beat_cnt_q == BW'(i)) slice = tgt_q[HASH_W-1-i*WORD_W -: WORD_W];
      end

      tgt_cat   = {tgt_data, tgt_q};
      beat_acc  = (state_q == RUN) && hash_valid;
      last_beat = (beat_cnt_q == BW'(NW - 1));

      // The first beat of a hash ignores flags left over from the previous hash.
      lt_prior = (beat_cnt_q == '0) ? 1'b0 : lt_q;
      gt_prior = (beat_cnt_q == '0) ? 1'b0 : gt_q;
      lt_cur   = lt_prior;
      gt_cur   = gt_prior;
      if (!lt_prior && !gt_prior) begin
         lt_cur = (hash_data < slice);
         gt_cur = (hash_data > slice);
      end

      if (stop) begin
         state_d    = IDLE;
         beat_cnt_d = '0;
         tgt_cnt_d  = '0;
      end else if (start) begin
         state_d       = LOAD;
         tgt_d         = '0;
         tgt_cnt_d     = '0;
         beat_cnt_d    = '0;
         hashes_done_d = '0;
         hits_found_d  = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (tgt_valid) begin
                  tgt_d = tgt_cat[HASH_W+TGT_W-1:TGT_W];
                  if (tgt_cnt_q == TW'(TGT_BEATS - 1)) begin
                     tgt_cnt_d = '0;
                     state_d   = RUN;
                  end else begin
                     tgt_cnt_d = tgt_cnt_q + 1'b1;
                  end
               end
            end
            RUN: begin
               if (beat_acc) begin
                  lt_d = lt_cur;
                  gt_d = gt_cur;
`ifdef HASH_CMP_CAPTURE_EN
                  asm_d = hash_cat[HASH_W-1:0];
`endif
                  if (last_beat) begin
                     beat_cnt_d    = '0;
                     hit_d         = lt_cur;
                     hit_valid_d   = 1'b1;
                     hashes_done_d = hashes_done_q + 1'b1;
                     if (lt_cur && (hits_found_q != '1)) hits_found_d = hits_found_q + 1'b1;
`ifdef HASH_CMP_CAPTURE_EN
                     hash_out_d = hash_cat[HASH_W-1:0];
`endif
                  end else begin
                     beat_cnt_d = beat_cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         tgt_q         <= '0;
         tgt_cnt_q     <= '0;
         beat_cnt_q    <= '0;
         lt_q          <= 1'b0;
         gt_q          <= 1'b0;
         hit_q         <= 1'b0;
         hit_valid_q   <= 1'b0;
         hashes_done_q <= '0;
         hits_found_q  <= '0;
      end else begin
         state_q       <= state_d;
         tgt_q         <= tgt_d;
         tgt_cnt_q     <= tgt_cnt_d;
         beat_cnt_q    <= beat_cnt_d;
         lt_q          <= lt_d;
         gt_q          <= gt_d;
         hit_q         <= hit_d;
         hit_valid_q   <= hit_valid_d;
         hashes_done_q <= hashes_done_d;
         hits_found_q  <= hits_found_d;
      end
   end

`ifdef HASH_CMP_CAPTURE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_q      <= '0;
         hash_out_q <= '0;
      end else begin
         asm_q      <= asm_d;
         hash_out_q <= hash_out_d;
      end
   end
   assign hash_out = hash_out_q;
`else
   assign hash_out = '0;
`endif

   assign hash_ready  = (state_q == RUN);
   assign running     = (state_q == RUN);
   assign hit_valid   = hit_valid_q;
   assign nonce_pop   = hit_valid_q;
   assign hit         = hit_q;
   assign hashes_done = hashes_done_q;
   assign hits_found  = hits_found_q;

endmodule

// File: tb/tb_hash_target_cmp.sv
// Directed self-checking bench for hash_target_cmp with default parameters.
module tb_hash_target_cmp;

   logic         clk, rst, start, stop, tgt_valid, hash_valid;
   logic [31:0]  tgt_data;
   logic [63:0]  hash_data;
   logic         hash_ready, hit_valid, hit, nonce_pop, running;
   logic [255:0] hash_out;
   logic [31:0]  hashes_done, hits_found;

   int checks   = 0;
   int failures = 0;

`ifdef HASH_CMP_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic [255:0] tgt_val, h1, h_gt, h_lt2, exp_ho;

   hash_target_cmp #(.HASH_W(256), .WORD_W(64), .TGT_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .tgt_data(tgt_data), .tgt_valid(tgt_valid),
      .hash_data(hash_data), .hash_valid(hash_valid), .hash_ready(hash_ready),
      .hit_valid(hit_valid), .hit(hit), .nonce_pop(nonce_pop), .hash_out(hash_out),
      .hashes_done(hashes_done), .hits_found(hits_found), .running(running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic load_target(input logic [255:0] t);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         tgt_valid = 1'b1;
         tgt_data  = t[i*32 +: 32];
      end
      @(negedge clk);
      tgt_valid = 1'b0;
   endtask

   task automatic send_hash(input logic [255:0] h);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         hash_valid = 1'b1;
         hash_data  = h[255-i*64 -: 64];
      end
      @(negedge clk);
      hash_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (hash_ready !== 1'b0) begin failures++; $display("FAIL rst_hash_ready got=%0h exp=0", hash_ready); end
      checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL rst_hit_valid got=%0h exp=0", hit_valid); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0h exp=0", hit); end
      checks++; if (nonce_pop !== 1'b0) begin failures++; $display("FAIL rst_nonce_pop got=%0h exp=0", nonce_pop); end
      checks++; if (hash_out !== 256'h0) begin failures++; $display("FAIL rst_hash_out got=%0h exp=0", hash_out); end
      checks++; if (hashes_done !== 32'h0) begin failures++; $display("FAIL rst_hashes_done got=%0h exp=0", hashes_done); end
      checks++; if (hits_found !== 32'h0) begin failures++; $display("FAIL rst_hits_found got=%0h exp=0", hits_found); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL rst_running got=%0h exp=0", running); end
      rst = 1'b0;
   endtask

   task automatic test_load();
      @(negedge clk);
      checks++; if (hash_ready !== 1'b0) begin failures++; $display("FAIL idle_hash_ready got=%0h exp=0", hash_ready); end
      load_target(tgt_val);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL load_running got=%0h exp=1", running); end
      checks++; if (hash_ready !== 1'b1) begin failures++; $display("FAIL load_hash_ready got=%0h exp=1", hash_ready); end
      checks++; if (hashes_done !== 32'd0) begin failures++; $display("FAIL load_done got=%0h exp=0", hashes_done); end
   endtask

   task automatic test_hit();
      send_hash(h1);
      exp_ho = CAP ? h1 : 256'h0;
      checks++; if (hit_valid !== 1'b1) begin failures++; $display("FAIL hit_valid got=%0h exp=1", hit_valid); end
      checks++; if (hit !== 1'b1) begin failures++; $display("FAIL hit_hit got=%0h exp=1", hit); end
      checks++; if (nonce_pop !== 1'b1) begin failures++; $display("FAIL hit_pop got=%0h exp=1", nonce_pop); end
      checks++; if (hashes_done !== 32'd1) begin failures++; $display("FAIL hit_done got=%0h exp=1", hashes_done); end
      checks++; if (hits_found !== 32'd1) begin failures++; $display("FAIL hit_found got=%0h exp=1", hits_found); end
      checks++; if (hash_out !== exp_ho) begin failures++; $display("FAIL hit_hash_out got=%0h exp=%0h", hash_out, exp_ho); end
      @(negedge clk);
      checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL hit_pulse_width got=%0h exp=0", hit_valid); end
      checks++; if (hash_out !== exp_ho) begin failures++; $display("FAIL hit_hash_out_hold got=%0h exp=%0h", hash_out, exp_ho); end
   endtask

   task automatic test_equal();
      send_hash(tgt_val);
      checks++; if (hit_valid !== 1'b1) begin failures++; $display("FAIL eq_valid got=%0h exp=1", hit_valid); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL eq_hit got=%0h exp=0", hit); end
      checks++; if (hashes_done !== 32'd2) begin failures++; $display("FAIL eq_done got=%0h exp=2", hashes_done); end
      checks++; if (hits_found !== 32'd1) begin failures++; $display("FAIL eq_found got=%0h exp=1", hits_found); end
   endtask

   task automatic test_no_sticky();
      send_hash(h_gt);
      checks++; if (hit_valid !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL gt_hit got=%0h/%0h exp=1/0", hit_valid, hit); end
      checks++; if (hits_found !== 32'd1) begin failures++; $display("FAIL gt_found got=%0h exp=1", hits_found); end
      send_hash(h_lt2);
      exp_ho = CAP ? h_lt2 : 256'h0;
      checks++; if (hit_valid !== 1'b1 || hit !== 1'b1) begin failures++; $display("FAIL lt2_hit got=%0h/%0h exp=1/1", hit_valid, hit); end
      checks++; if (hashes_done !== 32'd4) begin failures++; $display("FAIL lt2_done got=%0h exp=4", hashes_done); end
      checks++; if (hits_found !== 32'd2) begin failures++; $display("FAIL lt2_found got=%0h exp=2", hits_found); end
      checks++; if (hash_out !== exp_ho) begin failures++; $display("FAIL lt2_hash_out got=%0h exp=%0h", hash_out, exp_ho); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (hit_valid !== ((i % 4 == 0) && (i > 0))) begin failures++; $display("FAIL b2b_pulse_%0d got=%0h exp=%0h", i, hit_valid, ((i % 4 == 0) && (i > 0))); end
         checks++; if (hash_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0h exp=1", i, hash_ready); end
         hash_valid = 1'b1;
         hash_data  = 64'h0;
      end
      @(negedge clk);
      hash_valid = 1'b0;
      checks++; if (hit_valid !== 1'b1 || hit !== 1'b1) begin failures++; $display("FAIL b2b_last got=%0h/%0h exp=1/1", hit_valid, hit); end
      checks++; if (hashes_done !== 32'd8) begin failures++; $display("FAIL b2b_done got=%0h exp=8", hashes_done); end
      checks++; if (hits_found !== 32'd6) begin failures++; $display("FAIL b2b_found got=%0h exp=6", hits_found); end
   endtask

   task automatic test_stop();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         hash_valid = 1'b1;
         hash_data  = 64'h0;
      end
      @(negedge clk);
      hash_valid = 1'b0;
      stop       = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running got=%0h exp=0", running); end
      checks++; if (hash_ready !== 1'b0) begin failures++; $display("FAIL stop_ready got=%0h exp=0", hash_ready); end
      checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL stop_hit_valid got=%0h exp=0", hit_valid); end
      checks++; if (hashes_done !== 32'd8 || hits_found !== 32'd6) begin failures++; $display("FAIL stop_hold got=%0h/%0h exp=8/6", hashes_done, hits_found); end
      load_target(tgt_val);
      checks++; if (hashes_done !== 32'd0 || hits_found !== 32'd0) begin failures++; $display("FAIL restart_clear got=%0h/%0h exp=0/0", hashes_done, hits_found); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL restart_running got=%0h exp=1", running); end
      // Stop coinciding with the last beat drops that hash.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         hash_valid = 1'b1;
         hash_data  = 64'h0;
         stop       = (i == 3);
      end
      @(negedge clk);
      hash_valid = 1'b0;
      stop       = 1'b0;
      checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL stop_last_valid got=%0h exp=0", hit_valid); end
      checks++; if (hashes_done !== 32'd0) begin failures++; $display("FAIL stop_last_done got=%0h exp=0", hashes_done); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_last_running got=%0h exp=0", running); end
      load_target(tgt_val);
      send_hash(h1);
      checks++; if (hit_valid !== 1'b1 || hit !== 1'b1 || hashes_done !== 32'd1) begin failures++; $display("FAIL reload_hash got=%0h/%0h/%0h exp=1/1/1", hit_valid, hit, hashes_done); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         hash_valid = 1'b1;
         hash_data  = 64'h0;
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (running !== 1'b0 || hash_ready !== 1'b0) begin failures++; $display("FAIL arst_state got=%0h/%0h exp=0/0", running, hash_ready); end
      checks++; if (hashes_done !== 32'd0 || hits_found !== 32'd0) begin failures++; $display("FAIL arst_counts got=%0h/%0h exp=0/0", hashes_done, hits_found); end
      checks++; if (hit_valid !== 1'b0 || hit !== 1'b0 || nonce_pop !== 1'b0) begin failures++; $display("FAIL arst_hit got=%0h/%0h/%0h exp=0/0/0", hit_valid, hit, nonce_pop); end
      checks++; if (hash_out !== 256'h0) begin failures++; $display("FAIL arst_hash_out got=%0h exp=0", hash_out); end
      @(negedge clk);
      rst        = 1'b0;
      hash_valid = 1'b0;
      @(negedge clk);
      checks++; if (hash_ready !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL arst_idle got=%0h/%0h exp=0/0", hash_ready, running); end
      checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL arst_no_pulse got=%0h exp=0", hit_valid); end
   endtask

   initial begin
      start = 1'b0; stop = 1'b0; tgt_valid = 1'b0; tgt_data = '0;
      hash_valid = 1'b0; hash_data = '0; rst = 1'b1;
      tgt_val = 256'h1 << 224;
      h1      = {64'h00000000_FFFFFFFF, {3{64'hFFFFFFFF_FFFFFFFF}}};
      h_gt    = {64'h00000001_00000000, 64'h1, 64'h0, 64'h0};
      h_lt2   = {64'h00000000_FFFFFFFF, 64'h0, 64'h0, 64'h0};
      test_reset();
      test_load();
      test_hit();
      test_equal();
      test_no_sticky();
      test_back_to_back();
      test_stop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
